// File: rtl/tilt_rotate.sv
// tilt_rotate: re-samples the stored 80x40 grey frame about its centre
// so the tilt measured by the Hough stage is removed.
module tilt_rotate #(
  parameter int IMG_W = 80,
  parameter int IMG_H = 40,
  parameter int PIX_W = 8,
  parameter int FRAC = 8,
  parameter logic [PIX_W-1:0] FILL = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [31:0] degree,
  output logic [11:0]       rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic [6:0]        out_x,
  output logic [5:0]        out_y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ADDR, READ, OUT, DONE
  } state_t;

  // round(256*sin(d)) for d = 0..90; cos(d) reads entry 90-d
  localparam logic [8:0] SIN_T [0:90] = '{
    9'd0,   9'd4,   9'd9,   9'd13,  9'd18,
    9'd22,  9'd27,  9'd31,  9'd36,  9'd40,
    9'd44,  9'd49,  9'd53,  9'd58,  9'd62,
    9'd66,  9'd71,  9'd75,  9'd79,  9'd83,
    9'd88,  9'd92,  9'd96,  9'd100, 9'd104,
    9'd108, 9'd112, 9'd116, 9'd120, 9'd124,
    9'd128, 9'd132, 9'd136, 9'd139, 9'd143,
    9'd147, 9'd150, 9'd154, 9'd158, 9'd161,
    9'd165, 9'd168, 9'd171, 9'd175, 9'd178,
    9'd181, 9'd184, 9'd187, 9'd190, 9'd193,
    9'd196, 9'd199, 9'd202, 9'd204, 9'd207,
    9'd210, 9'd212, 9'd215, 9'd217, 9'd219,
    9'd222, 9'd224, 9'd226, 9'd228, 9'd230,
    9'd232, 9'd234, 9'd236, 9'd237, 9'd239,
    9'd241, 9'd242, 9'd243, 9'd245, 9'd246,
    9'd247, 9'd248, 9'd249, 9'd250, 9'd251,
    9'd252, 9'd253, 9'd254, 9'd254, 9'd255,
    9'd255, 9'd255, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  localparam logic signed [19:0] W20 = 20'(IMG_W);
  localparam logic signed [19:0] H20 = 20'(IMG_H);
  localparam logic signed [19:0] CX = 20'(IMG_W / 2);
  localparam logic signed [19:0] CY = 20'(IMG_H / 2);
  localparam logic signed [19:0] RND = 20'(1 << (FRAC - 1));
  localparam logic [11:0] W12 = 12'(IMG_W);
  localparam logic [6:0] XL = 7'(IMG_W - 1);
  localparam logic [5:0] YL = 6'(IMG_H - 1);

  state_t state;
  logic signed [6:0] tilt;
  logic signed [6:0] tilt_c;
  logic [5:0] t_abs;
  logic signed [9:0] cos_q, sin_q;
  logic signed [9:0] cos_l, sin_l;
  logic [6:0] x;
  logic [5:0] y;
  logic oob;

  logic signed [19:0] c20, s20, dx, dy;
  logic signed [19:0] px, py, sx, sy;
  logic [11:0] a12;
  logic oob_c;

  always_comb begin
    tilt_c = degree[6:0];
    if (degree > 32'sd45) tilt_c = 7'sd45;
    else if (degree < -32'sd45) tilt_c = -7'sd45;
  end

  assign t_abs = tilt[6] ? (~tilt[5:0] + 6'd1) : tilt[5:0];
  assign cos_l = $signed({1'b0, SIN_T[7'd90 - {1'b0, t_abs}]});
  assign sin_l = $signed({1'b0, SIN_T[{1'b0, t_abs}]});

  always_comb begin
    c20 = {{10{cos_q[9]}}, cos_q};
    s20 = {{10{sin_q[9]}}, sin_q};
    dx = $signed({13'd0, x}) - CX;
    dy = $signed({14'd0, y}) - CY;
    px = dx * c20 + dy * s20 + RND;
    py = dy * c20 - dx * s20 + RND;
    sx = CX + (px >>> FRAC);
    sy = CY + (py >>> FRAC);
    oob_c = (sx < 0) || (sx >= W20) || (sy < 0) || (sy >= H20);
    a12 = sy[11:0] * W12 + sx[11:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tilt      <= '0;
      cos_q     <= '0;
      sin_q     <= '0;
      x         <= '0;
      y         <= '0;
      oob       <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          tilt  <= tilt_c;
          busy  <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          cos_q <= cos_l;
          sin_q <= tilt[6] ? -sin_l : sin_l;
          x     <= '0;
          y     <= '0;
          state <= ADDR;
        end
        ADDR: begin
          oob     <= oob_c;
          rd_addr <= oob_c ? '0 : a12;
          state   <= READ;
        end
        READ: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ADDR;
          if (x == XL) begin
            x <= '0;
            if (y == YL) begin
              y     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              y <= y + 6'd1;
            end
          end else begin
            x <= x + 7'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // rd_addr is held through OUT, so the RAM keeps returning the same word
  assign out_data = !out_valid ? '0 : (oob ? FILL : rd_data);
  assign out_x = x;
  assign out_y = y;

endmodule

// File: tb/tb_tilt_rotate.sv
// tb_tilt_rotate: scoreboard bench for tilt_rotate against a
// floating-point-table rotation model and a behavioural frame RAM.
module tb_tilt_rotate;

  logic clk, rst, start, out_ready;
  logic [31:0] degree;
  logic [11:0] rd_addr;
  logic [7:0] rd_data, out_data;
  logic out_valid, busy, done;
  logic [6:0] out_x;
  logic [5:0] out_y;

  tilt_rotate dut (
    .clk(clk), .rst(rst), .start(start), .degree(degree),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [6:0] x;
    logic [5:0] y;
  } pix_t;

  logic [7:0] mem [0:3199];
  logic [7:0] ref45 [0:3199];
  pix_t sb[$];
  pix_t e;

  int n_chk, n_err;
  int cyc = 0;
  int c0, rel, acc, done_n, first_v, done_at, last_acc;
  int cur_deg, ref_mode;
  bit mon_en, bp_mode, hold_chk;
  logic [21:0] prev_bus;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    rd_data <= (rd_addr < 12'd3200) ? mem[rd_addr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_model(input int deg);
    int t, ta, c, s, dx, dy, px, py, sx, sy;
    real r;
    pix_t p;
    t = deg > 45 ? 45 : (deg < -45 ? -45 : deg);
    ta = t < 0 ? -t : t;
    r = ta * 3.14159265358979 / 180.0;
    c = $rtoi(256.0 * $cos(r) + 0.5);
    s = $rtoi(256.0 * $sin(r) + 0.5);
    if (t < 0) s = -s;
    for (int yy = 0; yy < 40; yy++)
      for (int xx = 0; xx < 80; xx++) begin
        dx = xx - 40;
        dy = yy - 20;
        px = dx * c + dy * s + 128;
        py = dy * c - dx * s + 128;
        sx = 40 + (px >>> 8);
        sy = 20 + (py >>> 8);
        p.x = 7'(xx);
        p.y = 6'(yy);
        if (sx < 0 || sx >= 80 || sy < 0 || sy >= 40) p.d = 8'd255;
        else p.d = mem[sy * 80 + sx];
        sb.push_back(p);
      end
  endtask

  always @(negedge clk) begin
    out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (mon_en) begin
      rel = cyc - c0 + 1;
      if (out_valid && first_v < 0) first_v = rel;
      if (done) begin
        done_n++;
        done_at = rel;
      end
      if (hold_chk)
        check("stall_hold", {10'd0, out_valid, out_data, out_x, out_y},
              {10'd0, prev_bus});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          check("pix_x", out_x, e.x);
          check("pix_y", out_y, e.y);
          check("pix_data", out_data, e.d);
        end
        if (cur_deg != 0 && out_x == 7'd40 && out_y == 6'd20) begin
          check("centre_addr", rd_addr, 1640);
          check("centre_data", out_data, mem[1640]);
        end
        if (cur_deg == 45 && out_x == 7'd0 && out_y == 6'd0)
          check("corner_fill", out_data, 255);
        if (ref_mode == 1 && acc < 3200) ref45[acc] = out_data;
        if (ref_mode == 2 && acc < 3200)
          check("clamp_eq45", out_data, ref45[acc]);
        acc++;
        last_acc = rel;
      end
      hold_chk = out_valid && !out_ready;
      prev_bus = {out_valid, out_data, out_x, out_y};
    end
  end

  task automatic check_idle_outs(input string pfx);
    check({pfx, "_rd_addr"}, rd_addr, 0);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_data"}, out_data, 0);
    check({pfx, "_x"}, out_x, 0);
    check({pfx, "_y"}, out_y, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
  endtask

  task automatic run_frame(input int deg, input bit bp,
                           input bit spur, input bit abort);
    bit fin;
    @(negedge clk);
    #1;
    degree = deg;
    cur_deg = deg;
    bp_mode = bp;
    sb.delete();
    push_model(deg);
    acc = 0;
    done_n = 0;
    first_v = -1;
    done_at = -1;
    last_acc = -1;
    hold_chk = 0;
    start = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    fin = 0;
    for (int n = 0; n < 40000 && !fin; n++) begin
      @(negedge clk);
      #1;
      start = (spur && n == 500);
      if (done_n > 0) fin = 1;
      if (abort && acc >= 1000) begin
        mon_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_idle_outs("async_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);
        return;
      end
    end
    start = 1'b0;
    check("timeout", fin, 1);
    repeat (2) @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("accepted", acc, 3200);
    check("sb_left", sb.size(), 0);
    check("done_pulses", done_n, 1);
    check("busy_after", busy, 0);
    check("first_valid", first_v, 4);
    check("done_after_acc", done_at, last_acc + 1);
    if (!bp) check("done_cycle", done_at, 9602);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    mon_en = 0;
    bp_mode = 0;
    hold_chk = 0;
    ref_mode = 0;
    cur_deg = 0;
    c0 = 0;
    start = 1'b0;
    degree = '0;
    for (int i = 0; i < 3200; i++) mem[i] = 8'(i);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outs("reset");
    rst = 1'b1;

    run_frame(0, 0, 0, 0);
    ref_mode = 1;
    run_frame(45, 0, 0, 0);
    ref_mode = 2;
    run_frame(90, 0, 0, 0);
    ref_mode = 0;
    run_frame(10, 0, 0, 0);
    run_frame(-10, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(0, 0, 0, 1);
    run_frame(-7, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tilt_rotate.md
Name: tilt_rotate

Overview:
Downstream neighbour of the Hough stage. Takes the detected tilt angle and re-samples the stored 80x40 grey frame about its centre so the frame comes out level. Source pixels are fetched from the frame buffer through a synchronous read port. Corrected pixels are emitted in raster order over a valid/ready handshake to the output writer.

Parameters:
IMG_W, 80, frame width in pixels
IMG_H, 40, frame height in pixels
PIX_W, 8, pixel width
FRAC, 8, fractional bits of the sin/cos table (Q1.8)
FILL, 8'd255, value emitted when the source coordinate falls outside the frame

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame; sampled only in IDLE
degree  in  32  signed tilt in whole degrees, from the Hough stage
rd_addr  out  12  frame-buffer read address, = sy*IMG_W + sx
rd_data  in  PIX_W  frame-buffer data, valid one cycle after rd_addr
out_valid  out  1  out_data/out_x/out_y hold a corrected pixel
out_ready  in  1  consumer accepts the pixel when out_valid && out_ready
out_data  out  PIX_W  corrected pixel
out_x  out  7  destination column 0..IMG_W-1
out_y  out  6  destination row 0..IMG_H-1
busy  out  1  high from the SETUP state through the last OUT state
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (rst=0, asynchronous) forces state IDLE and clears every output: rd_addr, out_valid, out_data, out_x, out_y, busy and done all go to 0. A reset mid-frame abandons the frame; the next frame needs a new start.
- FSM states:
  - IDLE: on start, latch the clamped tilt and go to SETUP. start is ignored in every other state.
  - SETUP: one cycle. Look up cos and sin of |tilt| from a 46-entry Q1.8 table (entries 0..45°, cos0=256, sin45=cos45=181). Negate sin when tilt<0. Set x=0, y=0. Go to ADDR.
  - ADDR: compute the source coordinate and register rd_addr. Go to READ.
  - READ: wait one cycle for the RAM. Go to OUT.
  - OUT: drive out_valid=1 and hold all outputs while out_ready=0. On acceptance, advance x (wrapping to 0 and incrementing y at IMG_W-1). Go to ADDR, or to DONE after pixel (79,39).
  - DONE: pulse done=1 for one cycle, then return to IDLE.
- Tilt clamp: tilt = degree if -45 <= degree <= 45; otherwise saturate to ±45 with the sign of degree.
- Coordinate math, signed, at least 20-bit internal width:
  - dx = x-40, dy = y-20.
  - sx = 40 + ((dx*cos + dy*sin + 128) >>> 8).
  - sy = 20 + ((dy*cos - dx*sin + 128) >>> 8).
  - >>> is an arithmetic shift (floor), so rounding is half-up.
- Bounds: if sx<0, sx>=IMG_W, sy<0 or sy>=IMG_H, set rd_addr=0 and out_data=FILL. Otherwise out_data=rd_data as captured in READ.
- Throughput: 3 cycles per pixel when out_ready stays high. With start at cycle 0:
  - first out_valid at cycle 4;
  - pixel k at cycle 4+3k;
  - last pixel at cycle 9601;
  - done at cycle 9602.
- Stall: out_valid, out_data, out_x and out_y are held unchanged until accepted. No pixel may be dropped or duplicated.
- busy is 0 in IDLE and DONE.

Test Plan:
- Identity: frame buffer mem[i]=i[7:0], degree=0, out_ready=1. Required: 3200 pixels, out_data for (x,y) = mem[y*80+x], first out_valid at cycle 4, done exactly at cycle 9602, busy low again afterwards.
- Centre invariance: degree ∈ {+10, -10, +45}. Pixel (40,20) must use rd_addr=1640 and give out_data=mem[1640]. Corner (0,0) at +45 must give sx=-2, so out_data=255 (FILL).
- Clamp and sign: degree=90 must produce an output stream identical to degree=45. degree=-7 must produce source coordinates computed with sin negated; compare against a software model.
- Backpressure: degree=0 with out_ready toggling in a pseudo-random pattern. Required: 3200 accepted pixels in raster order, no changes to out_* while stalled, done one cycle after the final accept.
- Reset and spurious start: assert rst=0 at pixel 1000. All outputs must be 0 immediately (asynchronously) and the state IDLE; a new start must restart from (0,0). A start pulse while busy=1 must have no effect.
